// File: rtl/parity_stream_engine.sv
// Streaming parity generator/checker with a 2-entry skid buffer on the output side.
// Generate mode attaches a computed parity bit to each word; check mode passes the
// received bit through and flags a mismatch against the selected parity rule.
// Optional feature macro: PARITY_ERR_CNT_EN adds the saturating err_cnt output.
module parity_stream_engine #(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned CNTW   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        mode_i,
    input  logic              check_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              in_par,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_par,
    output logic              out_err,
    input  logic              err_clr,
    output logic              err_sticky
`ifdef PARITY_ERR_CNT_EN
    ,
    output logic [CNTW-1:0]   err_cnt
`endif
);

    localparam logic [2:0] ModeOdd   = 3'b001;
    localparam logic [2:0] ModeEven  = 3'b010;
    localparam logic [2:0] ModeMark  = 3'b011;
    localparam logic [2:0] ModeSpace = 3'b100;

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e            state_q, state_d;
    logic              in_ready_q, in_ready_d;

    // Head entry drives the outputs; tail holds the second word while the head stalls.
    logic [DWIDTH-1:0] head_data_q, head_data_d;
    logic              head_par_q, head_par_d;
    logic              head_err_q, head_err_d;
    logic [DWIDTH-1:0] tail_data_q, tail_data_d;
    logic              tail_par_q, tail_par_d;
    logic              tail_err_q, tail_err_d;

    logic              sticky_q, sticky_d;

    logic              word_xor;
    logic              exp_par;
    logic              mode_active;
    logic              new_par;
    logic              new_err;
    logic              accept;
    logic              pop;
    logic              err_event;

    // Expected parity bit for the incoming word under the sampled mode.
    always_comb begin
        word_xor    = ^in_data;
        exp_par     = 1'b0;
        mode_active = 1'b1;
        case (mode_i)
            ModeOdd:   exp_par = ~word_xor;
            ModeEven:  exp_par = word_xor;
            ModeMark:  exp_par = 1'b1;
            ModeSpace: exp_par = 1'b0;
            default: begin
                exp_par     = 1'b0;
                mode_active = 1'b0;
            end
        endcase
        new_par = check_i ? in_par : exp_par;
        new_err = check_i && mode_active && (exp_par != in_par);
    end

    assign accept    = in_valid && in_ready_q;
    assign out_valid = (state_q != StEmpty);
    assign pop       = out_valid && out_ready;
    assign err_event = accept && new_err;

    // Skid buffer next-state: load, shift and occupancy tracking.
    always_comb begin
        state_d     = state_q;
        head_data_d = head_data_q;
        head_par_d  = head_par_q;
        head_err_d  = head_err_q;
        tail_data_d = tail_data_q;
        tail_par_d  = tail_par_q;
        tail_err_d  = tail_err_q;
        case (state_q)
            StEmpty: begin
                if (accept) begin
                    head_data_d = in_data;
                    head_par_d  = new_par;
                    head_err_d  = new_err;
                    state_d     = StOne;
                end
            end
            StOne: begin
                if (accept && !pop) begin
                    tail_data_d = in_data;
                    tail_par_d  = new_par;
                    tail_err_d  = new_err;
                    state_d     = StTwo;
                end else if (!accept && pop) begin
                    state_d = StEmpty;
                end else if (accept && pop) begin
                    head_data_d = in_data;
                    head_par_d  = new_par;
                    head_err_d  = new_err;
                end
            end
            StTwo: begin
                // in_ready is low here, so only a pop can happen.
                if (pop) begin
                    head_data_d = tail_data_q;
                    head_par_d  = tail_par_q;
                    head_err_d  = tail_err_q;
                    state_d     = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase
        in_ready_d = (state_d != StTwo);
    end

    // Sticky error flag: a new error beats a simultaneous clear.
    always_comb begin
        sticky_d = sticky_q;
        if (err_clr) begin
            sticky_d = 1'b0;
        end
        if (err_event) begin
            sticky_d = 1'b1;
        end
    end

    // State and data registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StEmpty;
            in_ready_q  <= 1'b1;
            head_data_q <= '0;
            head_par_q  <= 1'b0;
            head_err_q  <= 1'b0;
            tail_data_q <= '0;
            tail_par_q  <= 1'b0;
            tail_err_q  <= 1'b0;
            sticky_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            head_data_q <= head_data_d;
            head_par_q  <= head_par_d;
            head_err_q  <= head_err_d;
            tail_data_q <= tail_data_d;
            tail_par_q  <= tail_par_d;
            tail_err_q  <= tail_err_d;
            sticky_q    <= sticky_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_data   = head_data_q;
    assign out_par    = head_par_q;
    assign out_err    = head_err_q;
    assign err_sticky = sticky_q;

`ifdef PARITY_ERR_CNT_EN
    logic [CNTW-1:0] cnt_q, cnt_d;

    // Saturating error counter; an increment during clear leaves a count of one.
    always_comb begin
        cnt_d = cnt_q;
        if (err_event) begin
            if (err_clr) begin
                cnt_d = CNTW'(1);
            end else if (cnt_q != {CNTW{1'b1}}) begin
                cnt_d = cnt_q + CNTW'(1);
            end
        end else if (err_clr) begin
            cnt_d = '0;
        end
    end

    // Error counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign err_cnt = cnt_q;
`else
    // CNTW only sizes the counter; without it there is nothing to build.
    if (CNTW == 0) begin : g_no_cnt
    end
`endif

endmodule

// File: tb/tb_parity_stream_engine.sv
// Randomised bench for parity_stream_engine against a queue-based reference model.
// Builds with or without PARITY_ERR_CNT_EN.
module tb_parity_stream_engine;

    localparam int unsigned DWIDTH = 8;
    localparam int unsigned CNTW   = 2;
    localparam int          CntMax = (1 << CNTW) - 1;

    localparam logic [2:0] MNone  = 3'd0;
    localparam logic [2:0] MOdd   = 3'd1;
    localparam logic [2:0] MEven  = 3'd2;
    localparam logic [2:0] MMark  = 3'd3;
    localparam logic [2:0] MSpace = 3'd4;

    logic              clk;
    logic              rst;
    logic [2:0]        mode_i;
    logic              check_i;
    logic              in_valid;
    logic              in_ready;
    logic [DWIDTH-1:0] in_data;
    logic              in_par;
    logic              out_valid;
    logic              out_ready;
    logic [DWIDTH-1:0] out_data;
    logic              out_par;
    logic              out_err;
    logic              err_clr;
    logic              err_sticky;
`ifdef PARITY_ERR_CNT_EN
    logic [CNTW-1:0]   err_cnt;
`endif

    parity_stream_engine #(
        .DWIDTH (DWIDTH),
        .CNTW   (CNTW)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .mode_i     (mode_i),
        .check_i    (check_i),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_par     (in_par),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_par    (out_par),
        .out_err    (out_err),
        .err_clr    (err_clr),
        .err_sticky (err_sticky)
`ifdef PARITY_ERR_CNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DWIDTH-1:0] data;
        logic              par;
        logic              err;
        logic [2:0]        mode;
        logic              chk;
    } entry_t;

    entry_t exp_q[$];
    logic   sticky_m;
    int     cnt_m;
    logic   just_reset;
    int     n_checks;
    int     n_fails;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Parity bit required by the mode rule, from the number of set bits.
    function automatic logic ref_par(input logic [2:0] m, input logic [DWIDTH-1:0] d);
        int ones;
        ones = $countones(d);
        case (m)
            MOdd:   return ((ones % 2) == 0);
            MEven:  return ((ones % 2) == 1);
            MMark:  return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic compare_outputs();
        entry_t h;
        check_val("in_ready", in_ready, exp_q.size() < 2);
        check_val("out_valid", out_valid, exp_q.size() > 0);
        check_val("err_sticky", err_sticky, sticky_m);
`ifdef PARITY_ERR_CNT_EN
        check_val("err_cnt", err_cnt, cnt_m);
`endif
        if (exp_q.size() > 0) begin
            h = exp_q[0];
            check_val("out_data", out_data, h.data);
            check_val("out_par", out_par, h.par);
            check_val("out_err", out_err, h.err);
            if (out_ready && !h.chk && (h.mode == MEven || h.mode == MOdd)) begin
                check_val("word_parity", ^{out_par, out_data}, h.mode == MOdd);
            end
        end
        if (just_reset) begin
            check_val("rst_out_data", out_data, 0);
            check_val("rst_out_par", out_par, 0);
            check_val("rst_out_err", out_err, 0);
        end
    endtask

    // One clock: drive, check at negedge, advance the model at posedge.
    task automatic cyc(input logic v, input logic [DWIDTH-1:0] d, input logic p,
                       input logic [2:0] m, input logic c, input logic ordy,
                       input logic clr, input logic r);
        logic   acc;
        logic   hs;
        entry_t e;
        rst = r; in_valid = v; in_data = d; in_par = p;
        mode_i = m; check_i = c; out_ready = ordy; err_clr = clr;
        @(negedge clk);
        compare_outputs();
        acc = v && (exp_q.size() < 2);
        hs  = ordy && (exp_q.size() > 0);
        e.data = d;
        e.mode = m;
        e.chk  = c;
        e.par  = c ? p : ref_par(m, d);
        e.err  = c && (m >= MOdd) && (m <= MSpace) && (p != ref_par(m, d));
        @(posedge clk);
        if (r) begin
            exp_q.delete();
            sticky_m   = 1'b0;
            cnt_m      = 0;
            just_reset = 1'b1;
        end else begin
            just_reset = 1'b0;
            if (hs) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(e);
            if (acc && e.err) begin
                sticky_m = 1'b1;
                cnt_m    = clr ? 1 : ((cnt_m < CntMax) ? cnt_m + 1 : CntMax);
            end else if (clr) begin
                sticky_m = 1'b0;
                cnt_m    = 0;
            end
        end
        #1;
    endtask

    task automatic idle(input logic ordy);
        cyc(1'b0, '0, 1'b0, MNone, 1'b0, ordy, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks = 0; n_fails = 0;
        sticky_m = 1'b0; cnt_m = 0; just_reset = 1'b0;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_par = 1'b0;
        mode_i = MNone; check_i = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
        @(posedge clk);
        #1;
        cyc(1'b0, '0, 1'b0, MNone, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1'b1);

        // Generate EVEN back-to-back, then ODD/MARK/SPACE/reserved mode.
        cyc(1'b1, 8'hA5, 1'b0, MEven, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 8'h01, 1'b0, MEven, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 8'h00, 1'b0, MOdd, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 8'h5A, 1'b0, MMark, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 8'hFF, 1'b0, MSpace, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 8'h13, 1'b1, 3'b111, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Check EVEN: mismatch then match.
        cyc(1'b1, 8'h03, 1'b1, MEven, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 8'h03, 1'b0, MEven, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Plain clear, then clear together with an errored accept.
        cyc(1'b0, '0, 1'b0, MNone, 1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 8'h03, 1'b1, MEven, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(1'b1);

        // Saturation: five more errored words.
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 8'h81, 1'b1, MEven, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        idle(1'b1);
        idle(1'b1);

        // Backpressure: three words offered, two fit; hold, then release.
        cyc(1'b1, 8'h11, 1'b0, MOdd, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h22, 1'b0, MEven, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, 8'h33, 1'b0, MOdd, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        cyc(1'b1, 8'h33, 1'b0, MOdd, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 8'h33, 1'b0, MOdd, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Reset while full: buffered words must be discarded.
        cyc(1'b1, 8'h44, 1'b1, MEven, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'h55, 1'b0, MEven, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b0, MNone, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Random traffic with occasional clears and resets.
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom % 4) != 0, DWIDTH'($urandom), 1'($urandom),
                3'($urandom_range(0, 7)), 1'($urandom), ($urandom % 3) != 0,
                ($urandom % 16) == 0, ($urandom % 300) == 0);
        end
        for (int i = 0; i < 3; i++) idle(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
